// File: rtl/hazard_pkg.sv
// Shared types for the hazard / forwarding controller: FSM state encoding
// and the operand forward-select codes driven to the EX-stage muxes.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } fsm_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_WBB   = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: advance only while below the saturation value
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand forwarding for a 5-stage pipeline.
// Forward selects are pure combinational priority muxes (EX/MEM, MEM/WB,
// then the write-back buffer). Stalls, flushes and the global freeze come
// from a small RUN / MEM_WAIT / FLUSH state machine; a branch resolved while
// the pipe is frozen is remembered and flushed once the freeze lifts.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int CNT_W = 16,
    localparam int RAW   = $clog2(NREG)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    // ID stage
    input  logic [RAW-1:0]   i_rs1_IFID_addr,
    input  logic [RAW-1:0]   i_rs2_IFID_addr,
    // EX stage
    input  logic [RAW-1:0]   i_rs1_IDEX_addr,
    input  logic [RAW-1:0]   i_rs2_IDEX_addr,
    input  logic [RAW-1:0]   i_rd_waddr_IDEX,
    input  logic             i_clu_MemRead_IDEX,
    input  logic             i_branch_taken_EX,
    // MEM stage
    input  logic [RAW-1:0]   i_rd_waddr_EXMEM,
    input  logic [RAW-1:0]   i_rs2_EXMEM_addr,
    input  logic             i_clu_RegWrite_EXMEM,
    input  logic             i_clu_MemWrite_EXMEM,
    input  logic             i_clu_MemRead_EXMEM,
    input  logic             i_dmem_ready,
    // WB stage
    input  logic [RAW-1:0]   i_rd_waddr_MEMWB,
    input  logic             i_clu_RegWrite_MEMWB,
    input  logic             i_clu_MemRead_MEMWB,
    input  logic [XLEN-1:0]  i_wb_data_MEMWB,
    // Forwarding
    output logic [1:0]       o_forward_A,
    output logic [1:0]       o_forward_B,
    output logic             o_forward_store,
    output logic [XLEN-1:0]  o_wbb_data,
    // Pipeline control
    output logic             o_stall_PC,
    output logic             o_stall_IFID,
    output logic             o_bubble_IDEX,
    output logic             o_flush_IFID,
    output logic             o_flush_IDEX,
    output logic             o_freeze_all,
    // Performance counters
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    fsm_state_e       state_q, state_d;
    logic             pend_q, pend_d;
    logic             wbb_valid_q, wbb_valid_d;
    logic [RAW-1:0]   wbb_rd_q, wbb_rd_d;
    logic [XLEN-1:0]  wbb_data_q, wbb_data_d;

    logic             wait_cond;
    logic             load_use;
    logic             freeze;
    logic             flush;
    logic             stall;
    logic             fwd_store;

    function automatic logic [1:0] fwd_sel(
        input logic [RAW-1:0] rs,
        input logic           ex_we,
        input logic [RAW-1:0] ex_rd,
        input logic           wb_we,
        input logic [RAW-1:0] wb_rd,
        input logic           bb_v,
        input logic [RAW-1:0] bb_rd
    );
        if (ex_we && (ex_rd != '0) && (ex_rd == rs)) begin
            return FWD_EXMEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            return FWD_MEMWB;
        end else if (bb_v && (bb_rd != '0) && (bb_rd == rs)) begin
            return FWD_WBB;
        end
        return FWD_RF;
    endfunction

    assign o_forward_A = fwd_sel(i_rs1_IDEX_addr,
                                 i_clu_RegWrite_EXMEM, i_rd_waddr_EXMEM,
                                 i_clu_RegWrite_MEMWB, i_rd_waddr_MEMWB,
                                 wbb_valid_q, wbb_rd_q);
    assign o_forward_B = fwd_sel(i_rs2_IDEX_addr,
                                 i_clu_RegWrite_EXMEM, i_rd_waddr_EXMEM,
                                 i_clu_RegWrite_MEMWB, i_rd_waddr_MEMWB,
                                 wbb_valid_q, wbb_rd_q);

    // Hazard decode, control outputs and FSM next state
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        freeze    = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        fwd_store = 1'b0;

        wait_cond = (i_clu_MemRead_EXMEM | i_clu_MemWrite_EXMEM) & ~i_dmem_ready;
        load_use  = i_clu_MemRead_IDEX && (i_rd_waddr_IDEX != '0) &&
                    ((i_rd_waddr_IDEX == i_rs1_IFID_addr) ||
                     (i_rd_waddr_IDEX == i_rs2_IFID_addr));

        // Everything is held quiet while reset is asserted
        if (i_rst_n) begin
            freeze = (state_q == MEM_WAIT) ? ~i_dmem_ready : wait_cond;
            // Leaving a memory wait, only a branch that was seen while frozen
            // (and is still presented by the frozen EX stage) is flushed
            flush  = ~freeze & i_branch_taken_EX &
                     ((state_q != MEM_WAIT) | pend_q);
            stall  = load_use & ~flush & ~freeze;
            fwd_store = i_clu_MemWrite_EXMEM && i_clu_MemRead_MEMWB &&
                        i_clu_RegWrite_MEMWB && (i_rd_waddr_MEMWB != '0) &&
                        (i_rd_waddr_MEMWB == i_rs2_EXMEM_addr);
        end

        if (freeze && i_branch_taken_EX) begin
            pend_d = 1'b1;
        end else if (!freeze) begin
            pend_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (wait_cond) begin
                    state_d = MEM_WAIT;
                end else if (i_branch_taken_EX) begin
                    state_d = FLUSH;
                end
            end
            MEM_WAIT: begin
                if (i_dmem_ready) begin
                    state_d = RUN;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM state and deferred-branch flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Write-back buffer next value: follows MEM/WB unless the pipe is frozen
    always_comb begin
        wbb_valid_d = wbb_valid_q;
        wbb_rd_d    = wbb_rd_q;
        wbb_data_d  = wbb_data_q;
        if (!freeze) begin
            wbb_valid_d = i_clu_RegWrite_MEMWB;
            wbb_rd_d    = i_rd_waddr_MEMWB;
            wbb_data_d  = i_wb_data_MEMWB;
        end
    end

    // Write-back buffer register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wbb_valid_q <= 1'b0;
            wbb_rd_q    <= '0;
            wbb_data_q  <= '0;
        end else begin
            wbb_valid_q <= wbb_valid_d;
            wbb_rd_q    <= wbb_rd_d;
            wbb_data_q  <= wbb_data_d;
        end
    end

    assign o_wbb_data      = wbb_data_q;
    assign o_forward_store = fwd_store;
    assign o_freeze_all    = freeze;
    assign o_stall_PC      = stall;
    assign o_stall_IFID    = stall;
    assign o_bubble_IDEX   = stall;
    assign o_flush_IFID    = flush;
    assign o_flush_IDEX    = flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (freeze | stall),
        .count (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (flush),
        .count (o_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed scenarios plus random traffic. Each
// applied vector pushes its expected outputs into a queue; the entry is
// popped and compared on the following falling edge.
module tb_hazard_fwd_ctrl;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int CNT_W = 2;
    localparam int RAW   = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [RAW-1:0]   rs1_ifid, rs2_ifid, rs1_idex, rs2_idex, rd_idex;
    logic             mr_idex, br;
    logic [RAW-1:0]   rd_exmem, rs2_exmem;
    logic             rw_exmem, mw_exmem, mr_exmem, ready;
    logic [RAW-1:0]   rd_memwb;
    logic             rw_memwb, mr_memwb;
    logic [XLEN-1:0]  wb_data;
    logic [1:0]       fa, fb;
    logic             fst;
    logic [XLEN-1:0]  wbb_data;
    logic             stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, freeze;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic           rst_n;
        logic [RAW-1:0] rs1_ifid, rs2_ifid, rs1_idex, rs2_idex, rd_idex;
        logic           mr_idex, br;
        logic [RAW-1:0] rd_exmem, rs2_exmem;
        logic           rw_exmem, mw_exmem, mr_exmem, ready;
        logic [RAW-1:0] rd_memwb;
        logic           rw_memwb, mr_memwb;
        logic [XLEN-1:0] wb_data;
    } vec_t;

    typedef struct {
        logic [1:0]       fa, fb;
        logic             fst;
        logic [XLEN-1:0]  wbb;
        logic [5:0]       ctrl;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // reference model state (0 = RUN, 1 = MEM_WAIT, 2 = FLUSH)
    int             m_st;
    logic           m_pend, m_wv;
    logic [RAW-1:0] m_wrd;
    logic [XLEN-1:0] m_wdata;
    int             m_sc, m_fc;

    hazard_fwd_ctrl #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_rs1_IFID_addr      (rs1_ifid),
        .i_rs2_IFID_addr      (rs2_ifid),
        .i_rs1_IDEX_addr      (rs1_idex),
        .i_rs2_IDEX_addr      (rs2_idex),
        .i_rd_waddr_IDEX      (rd_idex),
        .i_clu_MemRead_IDEX   (mr_idex),
        .i_branch_taken_EX    (br),
        .i_rd_waddr_EXMEM     (rd_exmem),
        .i_rs2_EXMEM_addr     (rs2_exmem),
        .i_clu_RegWrite_EXMEM (rw_exmem),
        .i_clu_MemWrite_EXMEM (mw_exmem),
        .i_clu_MemRead_EXMEM  (mr_exmem),
        .i_dmem_ready         (ready),
        .i_rd_waddr_MEMWB     (rd_memwb),
        .i_clu_RegWrite_MEMWB (rw_memwb),
        .i_clu_MemRead_MEMWB  (mr_memwb),
        .i_wb_data_MEMWB      (wb_data),
        .o_forward_A          (fa),
        .o_forward_B          (fb),
        .o_forward_store      (fst),
        .o_wbb_data           (wbb_data),
        .o_stall_PC           (stall_pc),
        .o_stall_IFID         (stall_ifid),
        .o_bubble_IDEX        (bubble_idex),
        .o_flush_IFID         (flush_ifid),
        .o_flush_IDEX         (flush_idex),
        .o_freeze_all         (freeze),
        .o_stall_cnt          (stall_cnt),
        .o_flush_cnt          (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{default: '0};
        v.rst_n = 1'b1;
        v.ready = 1'b1;
        return v;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [RAW-1:0] rs, input vec_t v);
        if (v.rw_exmem && v.rd_exmem != 0 && v.rd_exmem == rs) return 2'b10;
        if (v.rw_memwb && v.rd_memwb != 0 && v.rd_memwb == rs) return 2'b01;
        if (m_wv && m_wrd != 0 && m_wrd == rs) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_st = 0; m_pend = 1'b0; m_wv = 1'b0; m_wrd = '0; m_wdata = '0;
        m_sc = 0; m_fc = 0;
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst_n;       rs1_ifid = v.rs1_ifid;   rs2_ifid = v.rs2_ifid;
        rs1_idex = v.rs1_idex; rs2_idex = v.rs2_idex;   rd_idex = v.rd_idex;
        mr_idex = v.mr_idex;   br = v.br;               rd_exmem = v.rd_exmem;
        rs2_exmem = v.rs2_exmem; rw_exmem = v.rw_exmem; mw_exmem = v.mw_exmem;
        mr_exmem = v.mr_exmem; ready = v.ready;         rd_memwb = v.rd_memwb;
        rw_memwb = v.rw_memwb; mr_memwb = v.mr_memwb;   wb_data = v.wb_data;
    endtask

    // apply one vector after a rising edge, check on the falling edge
    task automatic step(input vec_t v);
        exp_t e, g;
        logic wt, frz, fl, lu, stl;
        @(posedge clk);
        #1;
        drive(v);
        if (!v.rst_n) model_reset();
        wt  = (v.mr_exmem | v.mw_exmem) & ~v.ready;
        frz = v.rst_n & ((m_st == 1) ? ~v.ready : wt);
        fl  = v.rst_n & ~frz & v.br & ((m_st != 1) | m_pend);
        lu  = v.mr_idex && v.rd_idex != 0 && (v.rd_idex == v.rs1_ifid || v.rd_idex == v.rs2_ifid);
        stl = v.rst_n & lu & ~fl & ~frz;
        e.fa   = m_fwd(v.rs1_idex, v);
        e.fb   = m_fwd(v.rs2_idex, v);
        e.fst  = v.rst_n && v.mw_exmem && v.mr_memwb && v.rw_memwb &&
                 v.rd_memwb != 0 && v.rd_memwb == v.rs2_exmem;
        e.wbb  = m_wdata;
        e.ctrl = {stl, stl, stl, fl, fl, frz};
        e.sc   = CNT_W'(m_sc);
        e.fc   = CNT_W'(m_fc);
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 64'd1, 64'd0);
        end else begin
            g = exp_q.pop_front();
            check_val("fwd_A", fa, g.fa);
            check_val("fwd_B", fb, g.fb);
            check_val("fwd_store", fst, g.fst);
            check_val("wbb_data", wbb_data, g.wbb);
            check_val("ctrl", {stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, freeze}, g.ctrl);
            check_val("stall_cnt", stall_cnt, g.sc);
            check_val("flush_cnt", flush_cnt, g.fc);
        end
        if (v.rst_n) begin
            if (!frz) begin
                m_wv = v.rw_memwb; m_wrd = v.rd_memwb; m_wdata = v.wb_data;
            end
            if (frz && v.br) m_pend = 1'b1;
            else if (!frz) m_pend = 1'b0;
            case (m_st)
                0:       m_st = wt ? 1 : (v.br ? 2 : 0);
                1:       m_st = v.ready ? 0 : 1;
                default: m_st = 0;
            endcase
            if ((frz || stl) && m_sc < CMAX) m_sc++;
            if (fl && m_fc < CMAX) m_fc++;
        end
    endtask

    task automatic do_reset();
        vec_t v;
        v = idle_vec();
        v.rst_n = 1'b0;
        step(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        drive(idle_vec());
        model_reset();
        #1 rst_n = 1'b0;

        // reset state
        do_reset();
        check_val("rst_ctrl", {stall_pc, flush_idex, freeze, fst}, 4'b0000);
        check_val("rst_wbb", wbb_data, 32'h0);
        check_val("rst_cnt", {stall_cnt, flush_cnt}, 4'b0000);

        // EX/MEM beats MEM/WB
        v = idle_vec();
        v.rd_exmem = 5; v.rw_exmem = 1; v.rd_memwb = 5; v.rw_memwb = 1; v.rs1_idex = 5;
        step(v);
        check_val("fwdA_exmem_prio", fa, 2'b10);

        // MEM/WB only, and register 0 never matches
        v = idle_vec();
        v.rd_memwb = 6; v.rw_memwb = 1; v.rs1_idex = 6; v.rs2_idex = 0;
        v.rd_exmem = 0; v.rw_exmem = 1;
        step(v);
        check_val("fwdA_memwb", fa, 2'b01);
        check_val("fwdB_x0", fb, 2'b00);

        // WBB capture then WBB forward
        v = idle_vec();
        v.rd_memwb = 7; v.rw_memwb = 1; v.wb_data = 32'hDEADBEEF;
        step(v);
        v = idle_vec();
        v.rs2_idex = 7;
        step(v);
        check_val("fwdB_wbb", fb, 2'b11);
        check_val("wbb_data_val", wbb_data, 32'hDEADBEEF);

        // store-data forward from a load in MEM/WB
        v = idle_vec();
        v.mw_exmem = 1; v.ready = 1; v.mr_memwb = 1; v.rw_memwb = 1;
        v.rd_memwb = 4; v.rs2_exmem = 4;
        step(v);
        check_val("fwd_store_hit", fst, 1'b1);

        // load-use stall
        do_reset();
        v = idle_vec();
        v.mr_idex = 1; v.rd_idex = 3; v.rs2_ifid = 3;
        step(v);
        check_val("lu_stall", {stall_pc, stall_ifid, bubble_idex}, 3'b111);
        step(idle_vec());
        check_val("lu_stall_cnt", stall_cnt, 2'd1);
        check_val("lu_released", stall_pc, 1'b0);

        // load-use with rd = 0 is not a hazard
        v = idle_vec();
        v.mr_idex = 1; v.rd_idex = 0; v.rs1_ifid = 0;
        step(v);
        check_val("lu_x0", stall_pc, 1'b0);

        // flush overrides load-use
        do_reset();
        v = idle_vec();
        v.mr_idex = 1; v.rd_idex = 3; v.rs2_ifid = 3; v.br = 1;
        step(v);
        check_val("br_flush", {flush_ifid, flush_idex, stall_pc}, 3'b110);
        step(idle_vec());
        check_val("br_flush_cnt", flush_cnt, 2'd1);

        // branch deferred across a 3-cycle memory wait
        do_reset();
        v = idle_vec();
        v.mr_exmem = 1; v.ready = 0; v.br = 1;
        repeat (3) begin
            step(v);
            check_val("mw_freeze", {freeze, flush_idex}, 2'b10);
        end
        v.ready = 1;
        step(v);
        check_val("mw_deferred_flush", {freeze, flush_idex}, 2'b01);
        check_val("mw_stall_cnt", stall_cnt, 2'd3);

        // saturation, then reset in the middle of a freeze
        do_reset();
        v = idle_vec();
        v.mr_exmem = 1; v.ready = 0;
        repeat (6) step(v);
        check_val("sat_stall_cnt", stall_cnt, 2'd3);
        v.rst_n = 0;
        step(v);
        check_val("rst_mid_freeze", {freeze, stall_cnt}, 3'b000);
        step(idle_vec());
        check_val("post_rst_quiet", {freeze, flush_idex}, 2'b00);
        v = idle_vec();
        v.br = 1;
        step(v);
        check_val("post_rst_run_flush", flush_idex, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            v = idle_vec();
            v.rst_n     = ($urandom_range(0, 39) != 0);
            v.rs1_ifid  = RAW'($urandom_range(0, 3));
            v.rs2_ifid  = RAW'($urandom_range(0, 3));
            v.rs1_idex  = RAW'($urandom_range(0, 3));
            v.rs2_idex  = RAW'($urandom_range(0, 3));
            v.rd_idex   = RAW'($urandom_range(0, 3));
            v.mr_idex   = 1'($urandom_range(0, 1));
            v.br        = ($urandom_range(0, 3) == 0);
            v.rd_exmem  = RAW'($urandom_range(0, 3));
            v.rs2_exmem = RAW'($urandom_range(0, 3));
            v.rw_exmem  = 1'($urandom_range(0, 1));
            v.mw_exmem  = 1'($urandom_range(0, 1));
            v.mr_exmem  = 1'($urandom_range(0, 1));
            v.ready     = ($urandom_range(0, 3) != 0);
            v.rd_memwb  = RAW'($urandom_range(0, 3));
            v.rw_memwb  = 1'($urandom_range(0, 1));
            v.mr_memwb  = 1'($urandom_range(0, 1));
            v.wb_data   = $urandom;
            step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
